// File: rtl/pet_needs_core.sv
// rtl/pet_needs_core.sv - pet needs engine: decaying stat channels, refill events, health FSM
// Optional revive from DEAD (all evt bits rising together) enabled by PET_REVIVE_EN.
module pet_needs_core #(
    parameter int NUM_STATS   = 3,
    parameter int STAT_W      = 3,
    parameter int TICK_DIV    = 50000000,
    parameter int TEST_SHIFT  = 4,
    parameter int DECAY_TICKS = 8,
    parameter int REFILL      = 3,
    parameter int LOW_TH      = 2,
    parameter int DEATH_TICKS = 16,
    parameter int ENV_IDX     = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        test,
    input  logic                        env_bad,
    input  logic [NUM_STATS-1:0]        evt,
    output logic [NUM_STATS*STAT_W-1:0] stats,
    output logic [2:0]                  status,
    output logic [2:0]                  need_idx,
    output logic                        dead,
    output logic                        tick
);
    localparam int STAT_MAX   = (1 << STAT_W) - 1;
    localparam int EXT_W      = STAT_W + 2;
    localparam int DC_W       = $clog2(DECAY_TICKS + 1);
    localparam int DT_W       = $clog2(DEATH_TICKS + 1);
    localparam int P_TEST_RAW = TICK_DIV >> TEST_SHIFT;

    localparam logic [31:0]       P_NORM_LAST = 32'(TICK_DIV - 1);
    localparam logic [31:0]       P_TEST_LAST = 32'(((P_TEST_RAW < 1) ? 1 : P_TEST_RAW) - 1);
    localparam logic [EXT_W-1:0]  MAX_EXT     = EXT_W'(STAT_MAX);
    localparam logic [EXT_W-1:0]  REFILL_EXT  = EXT_W'(REFILL);
    localparam logic [STAT_W-1:0] LOW_V       = STAT_W'(LOW_TH);
    localparam logic [STAT_W-1:0] HALF_V      = STAT_W'(STAT_MAX >> 1);
    localparam logic [STAT_W-1:0] MAX_V       = STAT_W'(STAT_MAX);
    localparam logic [DC_W-1:0]   DC_LAST     = DC_W'(DECAY_TICKS - 1);
    localparam logic [DT_W-1:0]   DT_LAST     = DT_W'(DEATH_TICKS - 1);

    typedef enum logic [2:0] {
        ST_OK   = 3'd0,
        ST_NEED = 3'd1,
        ST_CRIT = 3'd2,
        ST_DEAD = 3'd7
    } state_t;

    state_t                        state, state_nxt;
    logic [31:0]                   pre_cnt;
    logic [31:0]                   pre_last;
    logic                          test_q;
    logic [NUM_STATS-1:0]          evt_q;
    logic [NUM_STATS-1:0]          rise;
    logic [DC_W-1:0]               dcnt [NUM_STATS];
    logic [DT_W-1:0]               death_cnt, death_nxt;
    logic [NUM_STATS*STAT_W-1:0]   stats_nxt;
    logic                          any_low, any_zero;
    logic [2:0]                    low_idx;
    logic                          revive;

    assign pre_last = test ? P_TEST_LAST : P_NORM_LAST;
    assign rise     = evt & ~evt_q;
    assign status   = state;
    assign dead     = (state == ST_DEAD);

`ifdef PET_REVIVE_EN
    assign revive = (state == ST_DEAD) && (&rise);
`else
    assign revive = 1'b0;
`endif

    // A flip of test restarts the period so the new rate takes effect cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
            test_q  <= 1'b0;
        end else begin
            test_q <= test;
            if (test != test_q) begin
                pre_cnt <= '0;
                tick    <= 1'b0;
            end else if (pre_cnt >= pre_last) begin
                pre_cnt <= '0;
                tick    <= 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 32'd1;
                tick    <= 1'b0;
            end
        end
    end

    // Refill saturates at max first, then the decrement floors at zero.
    always_comb begin : next_stats
        logic [EXT_W-1:0] sum;
        logic [EXT_W-1:0] dec;
        sum       = '0;
        dec       = '0;
        stats_nxt = stats;
        for (int i = 0; i < NUM_STATS; i++) begin
            sum = {2'b00, stats[i*STAT_W +: STAT_W]} + (rise[i] ? REFILL_EXT : '0);
            if (sum > MAX_EXT) sum = MAX_EXT;
            dec = '0;
            if (tick && dcnt[i] == DC_LAST)
                dec = (env_bad && i == ENV_IDX) ? EXT_W'(2) : EXT_W'(1);
            stats_nxt[i*STAT_W +: STAT_W] = (sum < dec) ? '0 : STAT_W'(sum - dec);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_q <= '0;
            stats <= {NUM_STATS{MAX_V}};
            for (int i = 0; i < NUM_STATS; i++) dcnt[i] <= '0;
        end else begin
            evt_q <= evt;
            if (revive) begin
                stats <= {NUM_STATS{HALF_V}};
            end else if (state != ST_DEAD) begin
                stats <= stats_nxt;
                for (int i = 0; i < NUM_STATS; i++)
                    if (tick) dcnt[i] <= (dcnt[i] == DC_LAST) ? '0 : dcnt[i] + 1'b1;
            end
        end
    end

    always_comb begin : scan
        logic [STAT_W-1:0] v;
        v        = '0;
        any_low  = 1'b0;
        any_zero = 1'b0;
        low_idx  = 3'd0;
        for (int i = NUM_STATS - 1; i >= 0; i--) begin
            v = stats[i*STAT_W +: STAT_W];
            if (v < LOW_V) begin
                any_low = 1'b1;
                low_idx = 3'(i);
            end
            if (v == '0) any_zero = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        death_nxt = death_cnt;
        if (state == ST_DEAD) begin
            if (revive) begin
                state_nxt = ST_OK;
                death_nxt = '0;
            end
        end else begin
            if (any_zero)     state_nxt = ST_CRIT;
            else if (any_low) state_nxt = ST_NEED;
            else              state_nxt = ST_OK;
            if (state == ST_CRIT && any_zero) begin
                if (tick) begin
                    if (death_cnt == DT_LAST) begin
                        state_nxt = ST_DEAD;
                        death_nxt = '0;
                    end else begin
                        death_nxt = death_cnt + 1'b1;
                    end
                end
            end else begin
                death_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_OK;
            death_cnt <= '0;
            need_idx  <= 3'd0;
        end else begin
            state     <= state_nxt;
            death_cnt <= death_nxt;
            need_idx  <= low_idx;
        end
    end
endmodule

// File: tb/tb_pet_needs_core.sv
// tb/tb_pet_needs_core.sv - directed self-checking bench for pet_needs_core
module tb_pet_needs_core;
    logic       clk = 1'b0;
    logic       reset;
    logic       test;
    logic       env_bad;
    logic [2:0] evt;
    logic [8:0] stats;
    logic [2:0] status;
    logic [2:0] need_idx;
    logic       dead;
    logic       tick;

    int n_checks = 0;
    int n_fail   = 0;

    pet_needs_core #(
        .NUM_STATS(3), .STAT_W(3), .TICK_DIV(4), .TEST_SHIFT(2), .DECAY_TICKS(2),
        .REFILL(3), .LOW_TH(2), .DEATH_TICKS(4), .ENV_IDX(0)
    ) dut (
        .clk(clk), .reset(reset), .test(test), .env_bad(env_bad), .evt(evt),
        .stats(stats), .status(status), .need_idx(need_idx), .dead(dead), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; test = 1'b0; env_bad = 1'b0; evt = 3'b000;

        // basic decay and refill making channel 1 the needy one
        do_reset();
        check_eq("rst_stats", 32'(stats), 32'o777);
        check_eq("rst_status", 32'(status), 0);
        check_eq("rst_dead", 32'(dead), 0);
        check_eq("rst_tick", 32'(tick), 0);
        cyc(4);
        check_eq("tick_e3", 32'(tick), 1);
        check_eq("stats_e3", 32'(stats), 32'o777);
        cyc(1);
        check_eq("tick_e4", 32'(tick), 0);
        cyc(4);
        check_eq("stats_e8", 32'(stats), 32'o666);
        check_eq("status_e8", 32'(status), 0);
        evt = 3'b101;
        cyc(1);
        evt = 3'b000;
        check_eq("refill_02", 32'(stats), 32'o767);
        cyc(39);
        check_eq("stats_e48", 32'(stats), 32'o212);
        check_eq("status_lat", 32'(status), 0);
        cyc(1);
        check_eq("status_need", 32'(status), 1);
        check_eq("need_idx1", 32'(need_idx), 1);
        evt = 3'b010;
        cyc(1);
        evt = 3'b000;
        check_eq("refill_1", 32'(stats), 32'o242);
        cyc(1);
        check_eq("status_ok", 32'(status), 0);
        check_eq("need_idx0", 32'(need_idx), 0);

        // held refill level produces a single refill
        do_reset();
        cyc(9);
        check_eq("hold_base", 32'(stats), 32'o666);
        evt = 3'b100;
        cyc(1);
        check_eq("hold_sat", 32'(stats), 32'o766);
        cyc(7);
        check_eq("hold_e16", 32'(stats), 32'o655);
        cyc(12);
        check_eq("hold_e28", 32'(stats), 32'o544);
        evt = 3'b000;
        cyc(1);
        check_eq("hold_rel", 32'(stats), 32'o544);

        // env_bad double decay on channel 0, then critical and death
        env_bad = 1'b1;
        do_reset();
        cyc(9);
        check_eq("env_e8", 32'(stats), 32'o665);
        cyc(8);
        check_eq("env_e16", 32'(stats), 32'o553);
        cyc(8);
        check_eq("env_e24", 32'(stats), 32'o441);
        cyc(8);
        check_eq("env_e32", 32'(stats), 32'o330);
        cyc(1);
        check_eq("status_crit", 32'(status), 2);
        check_eq("crit_idx", 32'(need_idx), 0);
        cyc(14);
        check_eq("crit_e47", 32'(status), 2);
        check_eq("dead_e47", 32'(dead), 0);
        cyc(1);
        check_eq("status_dead", 32'(status), 7);
        check_eq("dead_e48", 32'(dead), 1);
        check_eq("stats_e48d", 32'(stats), 32'o110);
        cyc(3);
        check_eq("dead_tick", 32'(tick), 1);
        evt = 3'b110;
        cyc(1);
        evt = 3'b000;
        cyc(8);
        check_eq("frozen", 32'(stats), 32'o110);
        check_eq("still_dead", 32'(status), 7);
        evt = 3'b111;
        cyc(1);
`ifdef PET_REVIVE_EN
        check_eq("revive_stats", 32'(stats), 32'o333);
        check_eq("revive_dead", 32'(dead), 0);
        check_eq("revive_status", 32'(status), 0);
`else
        check_eq("norev_stats", 32'(stats), 32'o110);
        check_eq("norev_dead", 32'(dead), 1);
        check_eq("norev_status", 32'(status), 7);
`endif
        evt = 3'b000;
        env_bad = 1'b0;
        do_reset();
        check_eq("rst2_stats", 32'(stats), 32'o777);
        check_eq("rst2_status", 32'(status), 0);
        check_eq("rst2_dead", 32'(dead), 0);

        // test mode: change clears the prescaler, then a tick every cycle
        cyc(1);
        test = 1'b1;
        cyc(1);
        check_eq("test_chg", 32'(tick), 0);
        cyc(1);
        check_eq("test_t1", 32'(tick), 1);
        cyc(1);
        check_eq("test_t2", 32'(tick), 1);
        cyc(1);
        check_eq("test_decay", 32'(stats), 32'o666);
        test = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pet_needs_core.md
Name: pet_needs_core

Overview:
- Parametrised needs engine for the pet; generalises the fixed three 3-bit need registers (hunger, energy, entertainment) to NUM_STATS channels of STAT_W bits.
- Each channel decays on a prescaled time tick and is refilled by a per-channel event.
- Derives a registered status code through a health state machine with sticky death.
- Sits between the sensor/button conditioning stage and the display/Nokia drivers.

Parameters:
- NUM_STATS, 3, number of need channels (1..8)
- STAT_W, 3, bits per channel; STAT_MAX = 2^STAT_W-1
- TICK_DIV, 50000000, clk cycles per time tick in normal mode (>=2)
- TEST_SHIFT, 4, test mode divides the tick period by 2^TEST_SHIFT (floor 1 cycle)
- DECAY_TICKS, 8, ticks between decrements of each channel
- REFILL, 3, amount added per refill event
- LOW_TH, 2, a channel below this value is "needy"
- DEATH_TICKS, 16, consecutive ticks in CRIT before DEAD
- ENV_IDX, 0, channel that decays double-speed when env_bad=1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- test  in  1  level; accelerate time
- env_bad  in  1  level; too hot or too cold
- evt  in  NUM_STATS  per-channel refill request, level or pulse; rising edge detected internally
- stats  out  NUM_STATS*STAT_W  channel i at [i*STAT_W +: STAT_W]
- status  out  3  0=OK, 1=NEED, 2=CRIT, 7=DEAD
- need_idx  out  3  lowest channel index below LOW_TH; 0 when none
- dead  out  1  high in DEAD
- tick  out  1  one-cycle pulse per time tick

Behaviour:
- Reset:
  - all stats = STAT_MAX; status=0; need_idx=0; dead=0; tick=0.
  - Prescaler, decay counters, death counter and edge registers cleared.
  - Reset wins over every other event in the same cycle.
- Prescaler:
  - Counts 0..P-1, with P = TICK_DIV, or max(1, TICK_DIV>>TEST_SHIFT) when test=1.
  - tick asserted in the cycle the count wraps to 0.
  - A change of test mid-count clears the prescaler. No tick is issued in that cycle.
- Decay:
  - Per channel, a counter advances on tick.
  - When it reaches DECAY_TICKS-1 it wraps and the channel decrements by 1.
  - ENV_IDX decrements by 2 when env_bad=1.
  - Saturates at 0.
- Refill:
  - evt[i] rising edge (evt[i]=1, previous sample 0) adds REFILL, saturating at STAT_MAX.
  - Held level produces one refill only.
- Simultaneous refill and decay on one channel in the same cycle:
  - Result = sat0(satMAX(v+REFILL) - dec).
  - Computed in STAT_W+2 bits.
- Stats update registered; value visible the cycle after the edge or tick.
- Status FSM, evaluated every clk on the current registered stats, output registered (1-cycle latency):
  - OK: no channel < LOW_TH.
  - NEED: some channel < LOW_TH, none = 0.
  - CRIT: some channel = 0.
  - OK, NEED and CRIT move freely among each other per the conditions above.
- Death counter:
  - Increments on tick while in CRIT; cleared on leaving CRIT.
  - Reaching DEATH_TICKS → DEAD.
- DEAD:
  - Sticky until reset; dead=1; stats frozen.
  - evt ignored; decay stops; tick keeps running.
- need_idx: priority encoder, lowest index wins; updated with status.

Optional Feature:
- Macro PET_REVIVE_EN.
- Defined: in DEAD, a cycle where every evt bit rises at once revives the pet.
  - All stats = STAT_MAX>>1; death counter cleared.
  - FSM re-evaluated from the next cycle; dead=0.
- Undefined: DEAD exits only via reset; that evt pattern is ignored.

Test Plan (NUM_STATS=3, STAT_W=3, TICK_DIV=4, DECAY_TICKS=2, REFILL=3, LOW_TH=2, DEATH_TICKS=4, TEST_SHIFT=2, ENV_IDX=0):
- Reset, idle 8 cycles → tick every 4 cycles; after 2 ticks all stats 7→6; status=0.
- Idle until channel 1 hits 1 → status=1, need_idx=1. Pulse evt[1] → stat1=4, status=0 next cycle.
- env_bad=1 from reset → stat0 decreases 7,5,3,1,0 every 2 ticks while others step by 1.
- evt[2] held high 20 cycles at stat2=6 → stat2=7 once (saturate), no second refill.
- No refill until a stat reaches 0 → status=2; after 4 further ticks status=7, dead=1; evt pulses leave stats frozen. Reset → all 7, status=0.
- test=1 → tick every cycle (4>>2=1). With PET_REVIVE_EN, in DEAD raise evt=3'b111 → stats=3, dead=0.
